// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers, data-memory req/ack master, writeback mux.
// Latency: ALU/PC+4 results reach W one edge after M; memory results reach W one edge after their ack.
// Backpressure: a memory op in M without ack raises StallMem, freezing EX/MEM and bubbling MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (bus timeout abort with sticky MemErr).
module mem_stage #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int AW             = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          RegWriteE,
   input  logic          MemWriteE,
   input  logic [1:0]    ResultSrcE,
   input  logic [4:0]    rdE,
   input  logic [31:0]   ALUResultE,
   input  logic [31:0]   WriteDataE,
   input  logic [31:0]   PCplus4E,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   input  logic [31:0]   dmem_rdata,
   input  logic          dmem_ack,
   output logic          StallMem,
   output logic          RegWriteM,
   output logic [4:0]    rdM,
   output logic [31:0]   ALUResultM,
   output logic          RegWriteW,
   output logic [4:0]    rdW,
   output logic [31:0]   ResultW,
   output logic          MemErr
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   // Elaboration guard: a zero timeout would abort before the bus could answer.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
      $error("mem_stage: TIMEOUT_CYCLES must be at least 1");
   end

   logic        MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [31:0] WriteDataM;
   logic [31:0] PCplus4M;

   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [31:0] PCplus4W;

   logic [0:0]  state;
   logic        mem_op_m;
   logic        abort;

   // ResultSrc 11 is an ALU result, so only explicit loads and stores touch memory.
   assign mem_op_m = MemWriteM | (ResultSrcM == 2'b01);

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;

   // The counter holds completed WAIT cycles; the abort fires in the cycle it would reach the limit.
   assign abort = (state == WAIT) & ~dmem_ack & (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Count unacknowledged WAIT cycles, clearing on completion, abort or leaving WAIT.
   always_ff @(posedge clk) begin
      if (!reset)
         wait_cnt <= '0;
      else if (state == WAIT && !dmem_ack && !abort)
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset)
         MemErr <= 1'b0;
      else if (abort)
         MemErr <= 1'b1;
   end
`else
   assign abort  = 1'b0;
   assign MemErr = 1'b0;
`endif

   // Both FSM states request while a memory op sits in M, so back-to-back ops have no idle gap.
   assign dmem_req   = mem_op_m;
   assign dmem_we    = MemWriteM;
   assign dmem_addr  = ALUResultM[AW-1:0];
   assign dmem_wdata = WriteDataM;
   assign StallMem   = mem_op_m & ~dmem_ack & ~abort;

   // EX/MEM register: frozen while the memory access is outstanding.
   always_ff @(posedge clk) begin
      if (!reset) begin
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         ResultSrcM <= 2'b00;
         rdM        <= 5'd0;
         ALUResultM <= 32'd0;
         WriteDataM <= 32'd0;
         PCplus4M   <= 32'd0;
      end else if (!StallMem) begin
         RegWriteM  <= RegWriteE;
         MemWriteM  <= MemWriteE;
         ResultSrcM <= ResultSrcE;
         rdM        <= rdE;
         ALUResultM <= ALUResultE;
         WriteDataM <= WriteDataE;
         PCplus4M   <= PCplus4E;
      end
   end

   // Bus FSM: IDLE issues the request, WAIT holds it until ack (or abort).
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (mem_op_m && !dmem_ack) state <= WAIT;
            WAIT:    if (dmem_ack || abort)     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // MEM/WB register: advances when M is not stalled, otherwise injects a bubble.
   always_ff @(posedge clk) begin
      if (!reset) begin
         RegWriteW  <= 1'b0;
         rdW        <= 5'd0;
         ResultSrcW <= 2'b00;
         ALUResultW <= 32'd0;
         ReadDataW  <= 32'd0;
         PCplus4W   <= 32'd0;
      end else if (!StallMem) begin
         RegWriteW  <= RegWriteM & ~abort;
         rdW        <= abort ? 5'd0 : rdM;
         ResultSrcW <= ResultSrcM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= (ResultSrcM == 2'b01 && !abort) ? dmem_rdata : 32'd0;
         PCplus4W   <= PCplus4M;
      end else begin
         RegWriteW  <= 1'b0;
         rdW        <= 5'd0;
      end
   end

   // Writeback select; 11 falls back to the ALU result.
   always_comb begin
      ResultW = ALUResultW;
      case (ResultSrcW)
         2'b01:   ResultW = ReadDataW;
         2'b10:   ResultW = PCplus4W;
         default: ResultW = ALUResultW;
      endcase
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized program against an in-order ISA-level model with a scoreboard.
// A bus responder with random latency serves memory; monitors pop expectations at W and at bus ack.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWriteE, MemWriteE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  rdE;
   logic [31:0] ALUResultE, WriteDataE, PCplus4E;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        StallMem, RegWriteM, RegWriteW, MemErr;
   logic [4:0]  rdM, rdW;
   logic [31:0] ALUResultM, ResultW;

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYCLES(4), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .rdE(rdE),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCplus4E(PCplus4E),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .StallMem(StallMem),
      .RegWriteM(RegWriteM), .rdM(rdM), .ALUResultM(ALUResultM),
      .RegWriteW(RegWriteW), .rdW(rdW), .ResultW(ResultW), .MemErr(MemErr)
   );

   typedef struct { logic [4:0] rd; logic [31:0] val; int due; } wb_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;

   wb_t  wb_q[$];
   bus_t bus_q[$];
   logic [31:0] model_mem [logic [31:0]];
   logic [31:0] bus_mem   [logic [31:0]];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int force_lat = -1;
   bit force_stray = 1'b0;
   int stall_cnt = 0, req_cnt = 0, req_first = -1, req_last = -1;

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return ~a ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (model_mem.exists(a)) return model_mem[a];
      return mem_init(a);
   endfunction

   function automatic logic [31:0] bus_read(input logic [31:0] a);
      if (bus_mem.exists(a)) return bus_mem[a];
      return mem_init(a);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic finish_now();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   task automatic clear_counters();
      stall_cnt = 0; req_cnt = 0; req_first = -1; req_last = -1;
   endtask

   task automatic set_bubble();
      RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 2'b00; rdE = 5'd0;
      ALUResultE = $urandom; WriteDataE = $urandom; PCplus4E = $urandom;
   endtask

   // Present one instruction at E; return just after the edge that captures it into M.
   task automatic issue(input logic rw, input logic mw, input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input bit expect_it);
      bit done;
      RegWriteE = rw; MemWriteE = mw; ResultSrcE = src; rdE = rd;
      ALUResultE = alu; WriteDataE = wd; PCplus4E = pc4;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (!StallMem) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL issue_timeout: StallMem stuck high for 200 cycles (cycle %0d)", cyc);
         finish_now();
      end
      if (expect_it) begin
         if (mw) begin
            bus_q.push_back('{1'b1, alu, wd});
            model_mem[alu] = wd;
         end else if (src == 2'b01) begin
            bus_q.push_back('{1'b0, alu, 32'd0});
            if (rw) wb_q.push_back('{rd, model_read(alu), -1});
         end else if (rw) begin
            wb_q.push_back('{rd, (src == 2'b10) ? pc4 : alu, cyc + 2});
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      repeat (4) issue(1'b0, 1'b0, 2'b00, 5'd0, $urandom, $urandom, $urandom, 1'b1);
   endtask

   // Cycle counter, read only at negedges.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Bus responder: random (or forced) latency per access, stray acks while idle.
   initial begin
      bit busy;
      int lat, wcnt;
      logic rst_at_edge, last_req, last_ack, last_we;
      logic [31:0] last_addr, last_wdata;
      busy = 1'b0; lat = 0; wcnt = 0;
      last_req = 1'b0; last_ack = 1'b0; last_we = 1'b0; last_addr = '0; last_wdata = '0;
      dmem_ack = 1'b0; dmem_rdata = '0;
      forever begin
         @(posedge clk);
         rst_at_edge = reset;
         if (rst_at_edge === 1'b1 && last_req && last_ack) begin
            if (last_we) bus_mem[last_addr] = last_wdata;
            busy = 1'b0;
         end
         if (rst_at_edge !== 1'b1) busy = 1'b0;
         #1;
         if (dmem_req === 1'b1) begin
            if (!busy) begin
               busy = 1'b1; wcnt = 0;
               lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            dmem_ack   = (wcnt == lat);
            dmem_rdata = dmem_ack ? bus_read(dmem_addr) : $urandom;
            wcnt++;
         end else begin
            busy       = 1'b0;
            dmem_ack   = force_stray ? 1'b1 : ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
         end
         last_req = (dmem_req === 1'b1); last_ack = dmem_ack; last_we = dmem_we;
         last_addr = dmem_addr; last_wdata = dmem_wdata;
      end
   end

   // Monitors: bus completions and writebacks checked against the scoreboard queues.
   initial forever begin
      wb_t  w;
      bus_t b;
      @(negedge clk);
      if (reset === 1'b1) begin
         if (StallMem) stall_cnt++;
         if (dmem_req) begin
            req_cnt++;
            if (req_first < 0) req_first = cyc;
            req_last = cyc;
         end
`ifndef MEM_TIMEOUT_EN
         check32("stall_rule", {31'd0, StallMem}, {31'd0, dmem_req & ~dmem_ack});
`endif
         if (dmem_req && dmem_ack) begin
            if (bus_q.size() == 0) begin
               check32("bus_unexpected_access", {31'd0, dmem_req}, 32'd0);
            end else begin
               b = bus_q.pop_front();
               check32("bus_we", {31'd0, dmem_we}, {31'd0, b.we});
               check32("bus_addr", dmem_addr, b.addr);
               if (b.we) check32("bus_wdata", dmem_wdata, b.wdata);
            end
         end
         if (RegWriteW) begin
            if (wb_q.size() == 0) begin
               check32("wb_unexpected_write", {31'd0, RegWriteW}, 32'd0);
            end else begin
               w = wb_q.pop_front();
               check32("wb_rd", {27'd0, rdW}, {27'd0, w.rd});
               check32("wb_result", ResultW, w.val);
               if (w.due >= 0) check32("wb_latency", cyc, w.due);
            end
         end
      end
   end

   initial begin
      #2000000;
      checks++; errors++;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      finish_now();
   end

   initial begin
      int k;
      logic [31:0] a, v;
      logic [4:0]  r;
      reset = 1'b0;
      set_bubble();
      repeat (2) @(posedge clk);
      #1;
      check32("rst_req", {31'd0, dmem_req}, 32'd0);
      check32("rst_stall", {31'd0, StallMem}, 32'd0);
      check32("rst_regwrite_m", {31'd0, RegWriteM}, 32'd0);
      check32("rst_regwrite_w", {31'd0, RegWriteW}, 32'd0);
      check32("rst_result_w", ResultW, 32'd0);
      check32("rst_memerr", {31'd0, MemErr}, 32'd0);
      reset = 1'b1;

      // ALU op flows through without stalling.
      clear_counters();
      issue(1'b1, 1'b0, 2'b00, 5'd5, 32'h10, 32'h0, 32'h4, 1'b1);
      check32("t1_alu_m", ALUResultM, 32'h10);
      check32("t1_rd_m", {27'd0, rdM}, 32'd5);
      check32("t1_regwrite_m", {31'd0, RegWriteM}, 32'd1);
      drain();
      check32("t1_stalls", stall_cnt, 0);

      // Load with three wait cycles.
      bus_mem[32'h100] = 32'hDEADBEEF;
      model_mem[32'h100] = 32'hDEADBEEF;
      force_lat = 3;
      clear_counters();
      issue(1'b1, 1'b0, 2'b01, 5'd7, 32'h100, 32'h0, 32'h8, 1'b1);
      drain();
      check32("t2_stalls", stall_cnt, 3);
      check32("t2_req_cycles", req_cnt, 4);

      // Zero-wait store.
      force_lat = 0;
      clear_counters();
      issue(1'b0, 1'b1, 2'b00, 5'd0, 32'h200, 32'h1234, 32'hC, 1'b1);
      drain();
      check32("t3_stalls", stall_cnt, 0);
      check32("t3_req_cycles", req_cnt, 1);

      // Back-to-back load and store, one wait each.
      force_lat = 1;
      clear_counters();
      issue(1'b1, 1'b0, 2'b01, 5'd9, 32'h100, 32'h0, 32'h10, 1'b1);
      issue(1'b0, 1'b1, 2'b00, 5'd0, 32'h104, 32'hCAFE_0001, 32'h14, 1'b1);
      drain();
      check32("t4_stalls", stall_cnt, 2);
      check32("t4_req_cycles", req_cnt, 4);
      check32("t4_req_contiguous", req_last - req_first + 1, 4);

      // Randomized program over a small address window.
      force_lat = -1;
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 5);
         a = 32'h300 + ($urandom_range(0, 7) << 2);
         v = $urandom;
         r = 5'($urandom_range(1, 31));
         case (k)
            0: issue(1'b0, 1'b0, 2'b00, 5'd0, v, $urandom, $urandom, 1'b1);
            1: issue(1'b1, 1'b0, 2'b00, r, v, $urandom, $urandom, 1'b1);
            2: issue(1'b1, 1'b0, 2'b10, r, v, $urandom, $urandom, 1'b1);
            3: issue(1'b1, 1'b0, 2'b11, r, v, $urandom, $urandom, 1'b1);
            4: issue(1'b1, 1'b0, 2'b01, r, a, $urandom, $urandom, 1'b1);
            default: issue(1'b0, 1'b1, 2'b00, 5'd0, a, v, $urandom, 1'b1);
         endcase
      end
      drain();

      // Reset while the bus is in WAIT; later acks must not matter.
      force_lat = 20;
      issue(1'b1, 1'b0, 2'b01, 5'd3, 32'h108, 32'h0, 32'h20, 1'b1);
      set_bubble();
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
      @(posedge clk); #1;
      wb_q.delete();
      bus_q.delete();
      force_stray = 1'b1;
      reset = 1'b1;
      check32("t5_req", {31'd0, dmem_req}, 32'd0);
      check32("t5_stall", {31'd0, StallMem}, 32'd0);
      check32("t5_regwrite_w", {31'd0, RegWriteW}, 32'd0);
      check32("t5_result_w", ResultW, 32'd0);
      check32("t5_memerr", {31'd0, MemErr}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         check32("t5_req_stray", {31'd0, dmem_req}, 32'd0);
         check32("t5_stall_stray", {31'd0, StallMem}, 32'd0);
         check32("t5_regwrite_w_stray", {31'd0, RegWriteW}, 32'd0);
      end
      @(posedge clk); #1;
      force_stray = 1'b0;
      force_lat = -1;
      for (int i = 0; i < 20; i++) begin
         v = $urandom;
         r = 5'($urandom_range(1, 31));
         if (i % 3 == 0) issue(1'b1, 1'b0, 2'b01, r, 32'h300 + 32'(i * 4 % 32), 32'h0, v, 1'b1);
         else            issue(1'b1, 1'b0, 2'b00, r, v, $urandom, $urandom, 1'b1);
      end
      drain();

`ifdef MEM_TIMEOUT_EN
      // Never-acked load aborts; the error flag sticks and later ops still work.
      force_lat = 1000;
      issue(1'b1, 1'b0, 2'b01, 5'd6, 32'h310, 32'h0, 32'h30, 1'b0);
      drain();
      check32("t6_memerr", {31'd0, MemErr}, 32'd1);
      force_lat = -1;
      issue(1'b1, 1'b0, 2'b00, 5'd11, 32'h55, 32'h0, 32'h34, 1'b1);
      drain();
      check32("t6_memerr_sticky", {31'd0, MemErr}, 32'd1);
`else
      check32("memerr_absent", {31'd0, MemErr}, 32'd0);
`endif

      check32("wb_queue_empty", wb_q.size(), 0);
      check32("bus_queue_empty", bus_q.size(), 0);
      finish_now();
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
EX→MEM→WB consumer side of the execute stage: holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory request/acknowledge bus. A memory access that waits on the bus stalls the upper pipeline.
Provides ALUResultM/rdM/RegWriteM forwarding taps to the hazard unit and selects ResultW for writeback and forwarding.

Parameters:
TIMEOUT_CYCLES, 15, max cycles in WAIT before abort (used only with MEM_TIMEOUT_EN)
AW, 32, data-memory address width

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-low reset
RegWriteE  in  1  EX register-write enable
MemWriteE  in  1  EX store
ResultSrcE  in  2  00 ALU, 01 load data, 10 PC+4
rdE  in  5  EX destination register
ALUResultE  in  32  EX ALU result / effective address
WriteDataE  in  32  forwarded store data (SrcBE)
PCplus4E  in  32  EX PC+4
dmem_req  out  1  memory request
dmem_we  out  1  1=write, 0=read
dmem_addr  out  AW  = ALUResultM[AW-1:0]
dmem_wdata  out  32  = WriteDataM
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete this cycle
StallMem  out  1  hold F/D/E stages and EX/MEM register
RegWriteM  out  1  forwarding tap
rdM  out  5  forwarding tap
ALUResultM  out  32  forwarding tap (ForwardAE/BE = 10)
RegWriteW  out  1  writeback enable
rdW  out  5  writeback destination
ResultW  out  32  writeback value (ForwardAE/BE = 01)
MemErr  out  1  sticky bus-timeout flag (0 when feature absent)

Behaviour:
- Reset (reset==0 at posedge): all EX/MEM and MEM/WB fields → 0, state → IDLE, wait counter → 0, MemErr → 0. After that edge: dmem_req=0, StallMem=0, RegWriteM=0, RegWriteW=0, ResultW=0. Reset mid-WAIT drops dmem_req on the next cycle; a late ack is ignored.
- MemOpM = MemWriteM | (ResultSrcM==01). A ResultSrc of 11 is treated as ALU.
- EX/MEM register: captures all E inputs when StallMem=0; holds when StallMem=1.
- dmem_req = MemOpM and state∈{IDLE,WAIT}, combinational. dmem_we = MemWriteM. addr/wdata stay stable while req is held.
- StallMem = MemOpM & ~dmem_ack, combinational. A zero-wait ack in the first cycle gives no stall.
- FSM:
  - IDLE→WAIT when MemOpM & ~ack.
  - WAIT→IDLE on ack.
  - Otherwise hold.
  - An ack while not requesting is ignored.
- MEM/WB register, every edge:
  - If StallMem=0: captures RegWriteM, rdM, ResultSrcM, ALUResultM, PCplus4M, and dmem_rdata (loads only; else 0).
  - If StallMem=1: inserts a bubble (RegWriteW=0, rdW=0). Other fields hold.
- Stores never write rd. RegWriteM on a store is passed through as given, since decode guarantees 0.
- ResultW mux (combinational): 00 ALUResultW, 01 ReadDataW, 10 PCplus4W, 11 ALUResultW.
- Back-to-back memory ops: the second enters M on the ack edge of the first. Its req is asserted the cycle after ack, with no idle gap.
- Latency: non-memory instruction reaches W one cycle after M. Memory instruction reaches W one cycle after its ack.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - Wait counter increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the access aborts that cycle: StallMem=0, MemErr set (sticky until reset), state→IDLE, counter→0.
  - The aborted instruction enters W with RegWriteW=0.
  - ack in the abort cycle wins: normal completion, no error.
- Undefined: no counter; WAIT persists indefinitely; MemErr tied to 0.

Test Plan:
1. Release reset, ADD result 0x0000_0010, rdE=5, RegWriteE=1, ResultSrcE=00 → next cycle ALUResultM=0x10, rdM=5. Cycle after: RegWriteW=1, rdW=5, ResultW=0x10. StallMem never asserts.
2. Load addr 0x100, ack held off 3 cycles, rdata 0xDEADBEEF → dmem_req=1 and we=0 for 4 cycles, StallMem=1 for 3 of them, RegWriteW=0 bubbles meanwhile. Cycle after ack: ResultW=0xDEADBEEF.
3. Store addr 0x200, data 0x1234, zero-wait ack → req=1, we=1, wdata=0x1234 for one cycle, StallMem=0, RegWriteW=0 next cycle.
4. Load then store back-to-back, each acked after 1 wait → req continuous, addresses switch on the first ack edge, two stall cycles total.
5. Reset asserted during WAIT with ack later pulsed → req=0 the cycle after reset, StallMem=0, RegWriteW=0, stray ack has no effect.
6. MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load never acked → abort after 4 WAIT cycles: MemErr=1 (stays 1), StallMem drops, RegWriteW=0. Next ALU instruction completes normally.
